// File: rtl/axi_bridge_pkg.sv
// Shared types and AXI constants for the N-port SRAM-to-AXI3 bridge.
package axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_WR,
    ST_B
  } state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // AXI AxSIZE encoding for a full-width beat.
  function automatic logic [2:0] axi_size(input int strb_w);
    return 3'($clog2(strb_w));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the port after the last winner has highest priority.
module rr_arbiter #(
  parameter  int NUM_PORTS = 2,
  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]     idx
);

  logic [IDX_W-1:0] last_q, last_d;

  // Scan from lowest to highest priority so the highest-priority requester wins.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] ci;
    gnt  = '0;
    idx  = '0;
    cand = 0;
    ci   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand = int'(last_q) + 1 + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      ci = IDX_W'(cand);
      if (req[ci]) begin
        gnt     = '0;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance) last_d = idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= IDX_W'(NUM_PORTS - 1);
    else        last_q <= last_d;
  end

endmodule

// File: rtl/axi_bridge_nport.sv
// Bridges NUM_PORTS SRAM-style requesters onto one AXI3 master, one transaction
// in flight: INCR read bursts up to 16 beats and single-beat strobed writes.
module axi_bridge_nport
  import axi_bridge_pkg::*;
#(
  parameter  int NUM_PORTS = 2,
  parameter  int ADDR_W    = 32,
  parameter  int DATA_W    = 32,
  parameter  int ID_W      = 4,
  localparam int STRB_W    = DATA_W / 8,
  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NUM_PORTS-1:0]        port_req,
  input  logic [NUM_PORTS*STRB_W-1:0] port_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] port_wdata,
  input  logic [NUM_PORTS*4-1:0]      port_len,
  output logic [NUM_PORTS-1:0]        port_gnt,
  output logic [NUM_PORTS-1:0]        port_rvalid,
  output logic [DATA_W-1:0]           port_rdata,
  output logic                        port_rlast,
  output logic [NUM_PORTS-1:0]        port_wdone,
  output logic [NUM_PORTS-1:0]        port_err,
  output logic [ID_W-1:0]             arid,
  output logic [ADDR_W-1:0]           araddr,
  output logic [3:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic                        arvalid,
  input  logic                        arready,
  input  logic [ID_W-1:0]             rid,
  input  logic [DATA_W-1:0]           rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready,
  output logic [ID_W-1:0]             awid,
  output logic [ADDR_W-1:0]           awaddr,
  output logic [3:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [ID_W-1:0]             wid,
  output logic [DATA_W-1:0]           wdata,
  output logic [STRB_W-1:0]           wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  input  logic [ID_W-1:0]             bid,
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready
);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       k_q, k_d;
  logic                   err_q, err_d;
  logic [NUM_PORTS-1:0]   port_gnt_q, port_gnt_d;
  logic [NUM_PORTS-1:0]   port_rvalid_q, port_rvalid_d;
  logic [DATA_W-1:0]      port_rdata_q, port_rdata_d;
  logic                   port_rlast_q, port_rlast_d;
  logic [NUM_PORTS-1:0]   port_wdone_q, port_wdone_d;
  logic [NUM_PORTS-1:0]   port_err_q, port_err_d;
  logic                   arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]      araddr_q, araddr_d;
  logic [ID_W-1:0]        arid_q, arid_d;
  logic [3:0]             arlen_q, arlen_d;
  logic                   awvalid_q, awvalid_d;
  logic [ADDR_W-1:0]      awaddr_q, awaddr_d;
  logic [ID_W-1:0]        awid_q, awid_d;
  logic                   wvalid_q, wvalid_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [STRB_W-1:0]      wstrb_q, wstrb_d;
  logic                   wlast_q, wlast_d;
  logic [ID_W-1:0]        wid_q, wid_d;

  logic [NUM_PORTS-1:0]   gnt_oh;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   arb_adv;

  logic [STRB_W-1:0]      we_arr    [NUM_PORTS];
  logic [ADDR_W-1:0]      addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0]      wdata_arr [NUM_PORTS];
  logic [3:0]             len_arr   [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign we_arr[g]    = port_we[g*STRB_W +: STRB_W];
    assign addr_arr[g]  = port_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = port_wdata[g*DATA_W +: DATA_W];
    assign len_arr[g]   = port_len[g*4 +: 4];
  end

  assign arb_adv = (state_q == ST_IDLE) && (|port_req);

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk     (aclk),
    .rst_n   (aresetn),
    .req     (port_req),
    .advance (arb_adv),
    .gnt     (gnt_oh),
    .idx     (gnt_idx)
  );

  // Responses are routed by the latched winner, so rid/bid are not needed.
  logic unused_ids;
  assign unused_ids = ^{rid, bid};

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    err_d         = err_q;
    port_gnt_d    = '0;
    port_rvalid_d = '0;
    port_rdata_d  = port_rdata_q;
    port_rlast_d  = 1'b0;
    port_wdone_d  = '0;
    port_err_d    = '0;
    arvalid_d     = arvalid_q;
    araddr_d      = araddr_q;
    arid_d        = arid_q;
    arlen_d       = arlen_q;
    awvalid_d     = awvalid_q;
    awaddr_d      = awaddr_q;
    awid_d        = awid_q;
    wvalid_d      = wvalid_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    wlast_d       = wlast_q;
    wid_d         = wid_q;
    case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (|port_req) begin
          k_d        = gnt_idx;
          port_gnt_d = gnt_oh;
          if (we_arr[gnt_idx] == '0) begin
            state_d   = ST_AR;
            arvalid_d = 1'b1;
            araddr_d  = addr_arr[gnt_idx];
            arid_d    = ID_W'(gnt_idx);
            arlen_d   = len_arr[gnt_idx];
          end else begin
            state_d   = ST_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = addr_arr[gnt_idx];
            awid_d    = ID_W'(gnt_idx);
            wid_d     = ID_W'(gnt_idx);
            wdata_d   = wdata_arr[gnt_idx];
            wstrb_d   = we_arr[gnt_idx];
            wlast_d   = 1'b1;
          end
        end
      end
      ST_AR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          state_d   = ST_R;
        end
      end
      ST_R: begin
        if (rvalid) begin
          port_rvalid_d[k_q] = 1'b1;
          port_rdata_d       = rdata;
          port_rlast_d       = rlast;
          if (rresp != RESP_OKAY) err_d = 1'b1;
          if (rlast) begin
            port_err_d[k_q] = err_d;
            state_d         = ST_IDLE;
          end
        end
      end
      ST_WR: begin
        // AW and W retire independently; move on once both are accepted.
        if (awready) awvalid_d = 1'b0;
        if (wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = ST_B;
      end
      ST_B: begin
        if (bvalid) begin
          port_wdone_d[k_q] = 1'b1;
          port_err_d[k_q]   = err_q || (bresp != RESP_OKAY);
          state_d           = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      k_q           <= '0;
      err_q         <= 1'b0;
      port_gnt_q    <= '0;
      port_rvalid_q <= '0;
      port_rdata_q  <= '0;
      port_rlast_q  <= 1'b0;
      port_wdone_q  <= '0;
      port_err_q    <= '0;
      arvalid_q     <= 1'b0;
      araddr_q      <= '0;
      arid_q        <= '0;
      arlen_q       <= '0;
      awvalid_q     <= 1'b0;
      awaddr_q      <= '0;
      awid_q        <= '0;
      wvalid_q      <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      wlast_q       <= 1'b0;
      wid_q         <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      err_q         <= err_d;
      port_gnt_q    <= port_gnt_d;
      port_rvalid_q <= port_rvalid_d;
      port_rdata_q  <= port_rdata_d;
      port_rlast_q  <= port_rlast_d;
      port_wdone_q  <= port_wdone_d;
      port_err_q    <= port_err_d;
      arvalid_q     <= arvalid_d;
      araddr_q      <= araddr_d;
      arid_q        <= arid_d;
      arlen_q       <= arlen_d;
      awvalid_q     <= awvalid_d;
      awaddr_q      <= awaddr_d;
      awid_q        <= awid_d;
      wvalid_q      <= wvalid_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      wlast_q       <= wlast_d;
      wid_q         <= wid_d;
    end
  end

  assign port_gnt    = port_gnt_q;
  assign port_rvalid = port_rvalid_q;
  assign port_rdata  = port_rdata_q;
  assign port_rlast  = port_rlast_q;
  assign port_wdone  = port_wdone_q;
  assign port_err    = port_err_q;
  assign arvalid     = arvalid_q;
  assign araddr      = araddr_q;
  assign arid        = arid_q;
  assign arlen       = arlen_q;
  assign arsize      = axi_size(STRB_W);
  assign arburst     = BURST_INCR;
  assign rready      = (state_q == ST_R);
  assign awvalid     = awvalid_q;
  assign awaddr      = awaddr_q;
  assign awid        = awid_q;
  assign awlen       = 4'd0;
  assign awsize      = axi_size(STRB_W);
  assign awburst     = BURST_INCR;
  assign wvalid      = wvalid_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign wlast       = wlast_q;
  assign wid         = wid_q;
  assign bready      = (state_q == ST_B);

endmodule

// File: tb/tb_axi_bridge_nport.sv
// Directed bench for axi_bridge_nport with a scripted AXI slave.
module tb_axi_bridge_nport;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int SW = DW / 8;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [NP-1:0]     port_req;
  logic [NP*SW-1:0]  port_we;
  logic [NP*AW-1:0]  port_addr;
  logic [NP*DW-1:0]  port_wdata;
  logic [NP*4-1:0]   port_len;
  logic [NP-1:0]     port_gnt, port_rvalid, port_wdone, port_err;
  logic [DW-1:0]     port_rdata;
  logic              port_rlast;
  logic [IW-1:0]     arid, rid, awid, wid, bid;
  logic [AW-1:0]     araddr, awaddr;
  logic [3:0]        arlen, awlen;
  logic [2:0]        arsize, awsize;
  logic [1:0]        arburst, awburst, rresp, bresp;
  logic              arvalid, arready, rlast, rvalid, rready;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [DW-1:0]     rdata, wdata;
  logic [SW-1:0]     wstrb;

  always #5 aclk = ~aclk;

  axi_bridge_nport #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .port_len(port_len), .port_gnt(port_gnt),
    .port_rvalid(port_rvalid), .port_rdata(port_rdata), .port_rlast(port_rlast),
    .port_wdone(port_wdone), .port_err(port_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic do_read(input int p, input logic [31:0] addr, input logic [3:0] len,
                         input logic [31:0] base, input logic [1:0] resp0,
                         input int gap_before, input bit exp_err);
    port_req[p]          = 1'b1;
    port_we[p*SW +: SW]  = '0;
    port_addr[p*AW +: AW] = addr;
    port_len[p*4 +: 4]   = len;
    tick;
    chk("rd_gnt", port_gnt, 64'(1) << p);
    chk("rd_arvalid", arvalid, 1);
    chk("rd_arid", arid, p);
    chk("rd_araddr", araddr, addr);
    chk("rd_arlen", arlen, len);
    chk("rd_arsize", arsize, 2);
    chk("rd_arburst", arburst, 1);
    port_req[p] = 1'b0;
    arready = 1'b1;
    tick;
    arready = 1'b0;
    chk("rd_ar_done", arvalid, 0);
    chk("rd_rready", rready, 1);
    for (int b = 0; b <= int'(len); b++) begin
      if (b == gap_before) begin
        rvalid = 1'b0;
        repeat (2) begin
          tick;
          chk("rd_gap", port_rvalid, 0);
        end
      end
      rvalid = 1'b1;
      rdata  = base + 32'(b);
      rlast  = (b == int'(len));
      rresp  = (b == 0) ? resp0 : 2'b00;
      rid    = IW'(p);
      tick;
      chk("rd_vld", port_rvalid, 64'(1) << p);
      chk("rd_data", port_rdata, base + 32'(b));
      chk("rd_last", port_rlast, (b == int'(len)) ? 1 : 0);
      chk("rd_err", port_err, (b == int'(len) && exp_err) ? (64'(1) << p) : 0);
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
    tick;
    chk("rd_quiet", port_rvalid, 0);
  endtask

  task automatic do_write(input int p, input logic [31:0] addr, input logic [3:0] we,
                          input logic [31:0] data, input int aw_dly, input int w_dly,
                          input logic [1:0] resp, input bit exp_err);
    int last_c;
    port_req[p]            = 1'b1;
    port_we[p*SW +: SW]    = we;
    port_addr[p*AW +: AW]  = addr;
    port_wdata[p*DW +: DW] = data;
    tick;
    chk("wr_gnt", port_gnt, 64'(1) << p);
    chk("wr_awvalid", awvalid, 1);
    chk("wr_wvalid", wvalid, 1);
    chk("wr_awaddr", awaddr, addr);
    chk("wr_awid", awid, p);
    chk("wr_wid", wid, p);
    chk("wr_awlen", awlen, 0);
    chk("wr_wstrb", wstrb, we);
    chk("wr_wdata", wdata, data);
    chk("wr_wlast", wlast, 1);
    port_req[p]         = 1'b0;
    port_we[p*SW +: SW] = '0;
    last_c = (aw_dly > w_dly) ? aw_dly : w_dly;
    for (int c = 0; c <= last_c; c++) begin
      awready = (c == aw_dly);
      wready  = (c == w_dly);
      tick;
      chk("wr_aw_hold", awvalid, (c < aw_dly) ? 1 : 0);
      chk("wr_w_hold", wvalid, (c < w_dly) ? 1 : 0);
      if (wvalid) chk("wr_wdata_stable", wdata, data);
    end
    awready = 1'b0;
    wready  = 1'b0;
    chk("wr_bready", bready, 1);
    tick;
    chk("wr_no_early_done", port_wdone, 0);
    bvalid = 1'b1;
    bresp  = resp;
    bid    = IW'(p);
    tick;
    chk("wr_done", port_wdone, 64'(1) << p);
    chk("wr_err", port_err, exp_err ? (64'(1) << p) : 0);
    bvalid = 1'b0;
    bresp  = 2'b00;
    tick;
    chk("wr_done_once", port_wdone, 0);
  endtask

  typedef struct {
    bit          wr;
    int          port;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
    logic [3:0]  len;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  resp;
    bit          exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic [NP-1:0] exp_g;

    vecs[0] = '{1'b0, 0, 32'h1FC0_0000, 4'b0000, 32'hDEAD_BEEF, 4'd0, 0, 0, 2'b00, 1'b0};
    vecs[1] = '{1'b1, 0, 32'h1000_0010, 4'b0011, 32'h1234_5678, 4'd0, 0, 3, 2'b00, 1'b0};
    vecs[2] = '{1'b1, 1, 32'h1000_0020, 4'b0011, 32'h1234_5678, 4'd0, 3, 0, 2'b00, 1'b0};
    vecs[3] = '{1'b1, 1, 32'h2000_0000, 4'b1111, 32'hCAFE_F00D, 4'd0, 1, 1, 2'b10, 1'b1};
    vecs[4] = '{1'b1, 1, 32'h2000_0004, 4'b1000, 32'h0BAD_F00D, 4'd0, 0, 0, 2'b00, 1'b0};
    vecs[5] = '{1'b0, 0, 32'h3000_0100, 4'b0000, 32'h0000_0100, 4'd1, 0, 0, 2'b10, 1'b1};
    vecs[6] = '{1'b0, 1, 32'h3000_0200, 4'b0000, 32'h5555_0000, 4'd0, 0, 0, 2'b00, 1'b0};

    aresetn = 1'b0;
    port_req = '0; port_we = '0; port_addr = '0; port_wdata = '0; port_len = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0; rid = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_gnt", port_gnt, 0);
    chk("rst_rvalid", port_rvalid, 0);
    chk("rst_wdone", port_wdone, 0);
    chk("rst_err", port_err, 0);
    chk("rst_araddr", araddr, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_wstrb", wstrb, 0);
    chk("rst_lens", {arlen, awlen}, 0);
    chk("rst_ids", {arid, awid, wid}, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_readies", {rready, bready}, 0);
    aresetn = 1'b1;
    tick;

    // Both ports requesting continuously, then port 1 alone.
    port_addr[0 +: AW]  = 32'h0000_0100;
    port_addr[AW +: AW] = 32'h0000_0200;
    port_len = '0;
    port_we  = '0;
    port_req = 2'b11;
    for (int t = 0; t < 6; t++) begin
      if (t == 4) port_req = 2'b10;
      exp_g = (t >= 4) ? 2'b10 : ((t % 2 == 0) ? 2'b01 : 2'b10);
      n = 0;
      do begin
        tick;
        n++;
      end while (port_gnt == '0 && n < 8);
      chk("arb_gnt", port_gnt, exp_g);
      chk("arb_arid", arid, (exp_g == 2'b01) ? 0 : 1);
      arready = 1'b1;
      tick;
      arready = 1'b0;
      rvalid = 1'b1; rlast = 1'b1; rdata = 32'(t); rresp = 2'b00;
      tick;
      chk("arb_rvalid", port_rvalid, exp_g);
      chk("arb_rdata", port_rdata, t);
      rvalid = 1'b0; rlast = 1'b0;
    end
    port_req = '0;
    tick;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].wr)
        do_write(vecs[i].port, vecs[i].addr, vecs[i].we, vecs[i].data,
                 vecs[i].aw_dly, vecs[i].w_dly, vecs[i].resp, vecs[i].exp_err);
      else
        do_read(vecs[i].port, vecs[i].addr, vecs[i].len, vecs[i].data,
                vecs[i].resp, -1, vecs[i].exp_err);
    end

    // Four-beat burst on port 1 with a two-cycle rvalid gap before the third beat.
    do_read(1, 32'h4000_0000, 4'd3, 32'h0000_0010, 2'b00, 2, 1'b0);

    // Reset asserted in the middle of a burst after two beats.
    port_req[0] = 1'b1;
    port_we[0 +: SW] = '0;
    port_addr[0 +: AW] = 32'h5000_0000;
    port_len[0 +: 4] = 4'd3;
    tick;
    port_req[0] = 1'b0;
    arready = 1'b1;
    tick;
    arready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      rvalid = 1'b1; rlast = 1'b0; rdata = 32'hAB00 + 32'(b); rresp = 2'b00;
      tick;
    end
    chk("mid_rvalid_before", port_rvalid, 2'b01);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_rvalid", port_rvalid, 0);
    rvalid = 1'b0;
    tick;
    tick;
    aresetn = 1'b1;
    tick;
    do_read(0, 32'h1FC0_0000, 4'd0, 32'hA5A5_0001, 2'b00, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
